// File: rtl/roce_pkg.sv
// Shared RoCE definitions: BTH opcodes for RC RDMA WRITE, PSN/QPN widths,
// and the state type of the write request generator. Also used by the
// TX framer and the ACK checker.
package roce_pkg;

  localparam int PSN_WIDTH = 24;
  localparam int QPN_WIDTH = 24;

  localparam logic [7:0] RC_RDMA_WRITE_FIRST  = 8'h06;
  localparam logic [7:0] RC_RDMA_WRITE_MIDDLE = 8'h07;
  localparam logic [7:0] RC_RDMA_WRITE_LAST   = 8'h08;
  localparam logic [7:0] RC_RDMA_WRITE_ONLY   = 8'h0A;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } wr_state_e;

  // PSN arithmetic is modulo 2**24; the natural wrap of a 24-bit add does it.
  function automatic logic [PSN_WIDTH-1:0] psn_next(input logic [PSN_WIDTH-1:0] psn);
    return psn + 24'd1;
  endfunction

endpackage

// File: rtl/roce_write_request_gen_512.sv
// RoCE RDMA WRITE request generator.
// Captures QP/transfer metadata on s_meta_valid and, when s_start_transfer is
// set, splits the transfer of s_dma_length bytes into PMTU-sized packets. One
// BTH/RETH descriptor per packet is presented on the m_desc_* interface with a
// valid/ready handshake; fields are registered and held until accepted.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_meta_valid ...    metadata pulse and captured QP/transfer fields
//   m_desc_valid/ready  descriptor handshake towards the TX framer
//   m_opcode .. m_pkt_length  descriptor fields
//   busy                transfer in progress
//   meta_drop_cnt       metadata pulses ignored while busy (saturating)
//   xfer_done_cnt       completed transfers (wrapping)
module roce_write_request_gen_512
  import roce_pkg::*;
#(
  parameter int PMTU_LOG2 = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_meta_valid,
  input  logic                 s_start_transfer,
  input  logic [31:0]          s_dma_length,
  input  logic [31:0]          s_r_key,
  input  logic [QPN_WIDTH-1:0] s_rem_qpn,
  input  logic [PSN_WIDTH-1:0] s_loc_psn,
  input  logic [31:0]          s_rem_ip_addr,
  input  logic [63:0]          s_rem_addr,
  output logic                 m_desc_valid,
  input  logic                 m_desc_ready,
  output logic [7:0]           m_opcode,
  output logic [PSN_WIDTH-1:0] m_psn,
  output logic [QPN_WIDTH-1:0] m_dest_qp,
  output logic [31:0]          m_ip_dest,
  output logic [63:0]          m_reth_vaddr,
  output logic [31:0]          m_reth_rkey,
  output logic [31:0]          m_reth_length,
  output logic [15:0]          m_pkt_length,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] meta_drop_cnt,
  output logic [CNT_WIDTH-1:0] xfer_done_cnt
);

  localparam logic [31:0] PMTU_BYTES = 32'd1 << PMTU_LOG2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  wr_state_e              state_r, state_s;

  // Captured metadata and transfer progress
  logic [31:0]            dma_len_r;
  logic [31:0]            r_key_r;
  logic [QPN_WIDTH-1:0]   rem_qpn_r;
  logic [31:0]            rem_ip_r;
  logic [63:0]            rem_addr_r;
  logic [31:0]            rem_len_r;   // bytes not yet handed to the framer
  logic [PSN_WIDTH-1:0]   psn_r;       // PSN of the next packet to present
  logic                   first_r;     // next packet is the first of the transfer
  logic                   last_pkt_r;  // presented descriptor is LAST/ONLY

  logic                   meta_take_s;
  logic                   meta_drop_s;
  logic                   load_s;
  logic                   hs_s;
  logic                   done_s;
  logic                   last_s;
  logic [7:0]             opcode_s;
  logic [15:0]            pkt_len_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_s     = state_r;
    meta_take_s = 1'b0;
    meta_drop_s = 1'b0;
    load_s      = 1'b0;
    hs_s        = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s_meta_valid) begin
          meta_take_s = 1'b1;
          if (s_start_transfer) begin
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Metadata arriving while busy, including the final-handshake cycle, is dropped.
        meta_drop_s = s_meta_valid;
        if (m_desc_valid) begin
          if (m_desc_ready) begin
            hs_s = 1'b1;
            if (last_pkt_r) begin
              done_s  = 1'b1;
              state_s = ST_IDLE;
            end else begin
              state_s = ST_ISSUE;
            end
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          // Either the first cycle after launch or the bubble after a handshake.
          load_s  = 1'b1;
          state_s = ST_ISSUE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Opcode and payload size of the next descriptor from remaining length
  always_comb begin
    last_s = (rem_len_r <= PMTU_BYTES);
    if (last_s) begin
      opcode_s  = first_r ? RC_RDMA_WRITE_ONLY : RC_RDMA_WRITE_LAST;
      pkt_len_s = rem_len_r[15:0];
    end else begin
      opcode_s  = first_r ? RC_RDMA_WRITE_FIRST : RC_RDMA_WRITE_MIDDLE;
      pkt_len_s = PMTU_BYTES[15:0];
    end
  end

  // Metadata capture, descriptor registers and transfer progress
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_len_r     <= 32'd0;
      r_key_r       <= 32'd0;
      rem_qpn_r     <= 24'd0;
      rem_ip_r      <= 32'd0;
      rem_addr_r    <= 64'd0;
      rem_len_r     <= 32'd0;
      psn_r         <= 24'd0;
      first_r       <= 1'b0;
      last_pkt_r    <= 1'b0;
      m_desc_valid  <= 1'b0;
      m_opcode      <= 8'd0;
      m_psn         <= 24'd0;
      m_dest_qp     <= 24'd0;
      m_ip_dest     <= 32'd0;
      m_reth_vaddr  <= 64'd0;
      m_reth_rkey   <= 32'd0;
      m_reth_length <= 32'd0;
      m_pkt_length  <= 16'd0;
      busy          <= 1'b0;
    end else begin
      busy <= (state_s == ST_ISSUE);
      if (meta_take_s) begin
        dma_len_r  <= s_dma_length;
        r_key_r    <= s_r_key;
        rem_qpn_r  <= s_rem_qpn;
        rem_ip_r   <= s_rem_ip_addr;
        rem_addr_r <= s_rem_addr;
        rem_len_r  <= s_dma_length;
        psn_r      <= s_loc_psn;
        first_r    <= 1'b1;
      end else if (load_s) begin
        m_desc_valid  <= 1'b1;
        m_opcode      <= opcode_s;
        m_psn         <= psn_r;
        m_dest_qp     <= rem_qpn_r;
        m_ip_dest     <= rem_ip_r;
        m_reth_vaddr  <= rem_addr_r;
        m_reth_rkey   <= r_key_r;
        m_reth_length <= dma_len_r;
        m_pkt_length  <= pkt_len_s;
        last_pkt_r    <= last_s;
      end else if (hs_s) begin
        m_desc_valid <= 1'b0;
        rem_len_r    <= rem_len_r - {16'd0, m_pkt_length};
        psn_r        <= psn_next(psn_r);
        first_r      <= 1'b0;
      end else begin
        m_desc_valid <= m_desc_valid;
      end
    end
  end

  // Statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_drop_cnt <= {CNT_WIDTH{1'b0}};
      xfer_done_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      if (meta_drop_s && (meta_drop_cnt != CNT_MAX)) begin
        meta_drop_cnt <= meta_drop_cnt + CNT_ONE;
      end else begin
        meta_drop_cnt <= meta_drop_cnt;
      end
      if (done_s) begin
        xfer_done_cnt <= xfer_done_cnt + CNT_ONE;
      end else begin
        xfer_done_cnt <= xfer_done_cnt;
      end
    end
  end

endmodule

// File: tb/tb_roce_write_request_gen_512.sv
// Directed testbench for roce_write_request_gen_512 (PMTU 1024 bytes).
module tb_roce_write_request_gen_512;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_meta_valid;
  logic        s_start_transfer;
  logic [31:0] s_dma_length;
  logic [31:0] s_r_key;
  logic [23:0] s_rem_qpn;
  logic [23:0] s_loc_psn;
  logic [31:0] s_rem_ip_addr;
  logic [63:0] s_rem_addr;
  logic        m_desc_valid;
  logic        m_desc_ready;
  logic [7:0]  m_opcode;
  logic [23:0] m_psn;
  logic [23:0] m_dest_qp;
  logic [31:0] m_ip_dest;
  logic [63:0] m_reth_vaddr;
  logic [31:0] m_reth_rkey;
  logic [31:0] m_reth_length;
  logic [15:0] m_pkt_length;
  logic        busy;
  logic [15:0] meta_drop_cnt;
  logic [15:0] xfer_done_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_done = 0;

  logic [7:0]  c_op   [16];
  logic [23:0] c_psn  [16];
  logic [15:0] c_len  [16];
  logic [63:0] c_va   [16];
  logic [31:0] c_rk   [16];
  logic [31:0] c_rl   [16];
  logic [23:0] c_qp   [16];
  logic [31:0] c_ip   [16];

  roce_write_request_gen_512 #(.PMTU_LOG2(10), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_meta_valid(s_meta_valid), .s_start_transfer(s_start_transfer),
    .s_dma_length(s_dma_length), .s_r_key(s_r_key), .s_rem_qpn(s_rem_qpn),
    .s_loc_psn(s_loc_psn), .s_rem_ip_addr(s_rem_ip_addr), .s_rem_addr(s_rem_addr),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .m_opcode(m_opcode), .m_psn(m_psn), .m_dest_qp(m_dest_qp), .m_ip_dest(m_ip_dest),
    .m_reth_vaddr(m_reth_vaddr), .m_reth_rkey(m_reth_rkey), .m_reth_length(m_reth_length),
    .m_pkt_length(m_pkt_length), .busy(busy),
    .meta_drop_cnt(meta_drop_cnt), .xfer_done_cnt(xfer_done_cnt)
  );

  always #5 clk = ~clk;

  // One-cycle metadata pulse; called and returns on a falling edge.
  task automatic pulse_meta(input logic start, input logic [31:0] len, input logic [31:0] rkey,
                            input logic [23:0] qpn, input logic [23:0] psn,
                            input logic [31:0] ip, input logic [63:0] va);
    s_meta_valid = 1'b1; s_start_transfer = start; s_dma_length = len; s_r_key = rkey;
    s_rem_qpn = qpn; s_loc_psn = psn; s_rem_ip_addr = ip; s_rem_addr = va;
    @(negedge clk);
    s_meta_valid = 1'b0; s_start_transfer = 1'b0;
  endtask

  // Accepts up to n descriptors (ready always high) and records their fields.
  task automatic collect(input int n, output int got);
    int cyc = 0;
    got = 0;
    while (got < n && cyc < 200) begin
      m_desc_ready = 1'b1;
      if (m_desc_valid) begin
        c_op[got] = m_opcode; c_psn[got] = m_psn; c_len[got] = m_pkt_length;
        c_va[got] = m_reth_vaddr; c_rk[got] = m_reth_rkey; c_rl[got] = m_reth_length;
        c_qp[got] = m_dest_qp; c_ip[got] = m_ip_dest;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    m_desc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (m_desc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", m_desc_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (meta_drop_cnt !== 16'd0 || xfer_done_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h/%h exp 0/0", meta_drop_cnt, xfer_done_cnt); end
    n_tests++; if ({m_opcode, m_psn, m_pkt_length, m_reth_length} !== 72'd0) begin n_fail++; $display("FAIL reset_fields got %h/%h/%h/%h exp 0", m_opcode, m_psn, m_pkt_length, m_reth_length); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_four_packets();
    int got;
    logic [7:0] exp_op [4];
    exp_op[0] = 8'h06; exp_op[1] = 8'h07; exp_op[2] = 8'h07; exp_op[3] = 8'h08;
    pulse_meta(1'b1, 32'd4096, 32'hCAFE0001, 24'h000ABC, 24'h000010, 32'hC0A80105, 64'h0000_1000_0000_0000);
    collect(4, got);
    n_tests++; if (got !== 4) begin n_fail++; $display("FAIL four_count got %0d exp 4", got); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (c_op[i] !== exp_op[i] || c_psn[i] !== 24'h10 + 24'(i) || c_len[i] !== 16'd1024) begin
        n_fail++;
        $display("FAIL four_pkt%0d got op=%h psn=%h len=%0d exp op=%h psn=%h len=1024",
                 i, c_op[i], c_psn[i], c_len[i], exp_op[i], 24'h10 + 24'(i));
      end
    end
    n_tests++;
    if (c_qp[0] !== 24'h000ABC || c_ip[0] !== 32'hC0A80105 || c_rl[0] !== 32'd4096) begin
      n_fail++; $display("FAIL four_hdr got qp=%h ip=%h rl=%0d exp 000abc/c0a80105/4096", c_qp[0], c_ip[0], c_rl[0]);
    end
    exp_done++;
    n_tests++; if (xfer_done_cnt !== 16'(exp_done) || busy !== 1'b0) begin n_fail++; $display("FAIL four_done got cnt=%0d busy=%b exp %0d/0", xfer_done_cnt, busy, exp_done); end
  endtask

  task automatic test_single_packet();
    int got;
    pulse_meta(1'b1, 32'd100, 32'h12345678, 24'h000042, 24'h000500, 32'h0A000001, 64'hDEAD_BEEF_0000_0040);
    n_tests++; if (m_desc_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL lat_cycle1 got valid=%b busy=%b exp 0/1", m_desc_valid, busy); end
    @(negedge clk);
    n_tests++; if (m_desc_valid !== 1'b1) begin n_fail++; $display("FAIL lat_cycle2 got valid=%b exp 1", m_desc_valid); end
    collect(1, got);
    n_tests++;
    if (got !== 1 || c_op[0] !== 8'h0A || c_len[0] !== 16'd100 || c_rl[0] !== 32'd100 || c_psn[0] !== 24'h000500) begin
      n_fail++; $display("FAIL only_pkt got n=%0d op=%h len=%0d rl=%0d psn=%h exp 1/0a/100/100/000500", got, c_op[0], c_len[0], c_rl[0], c_psn[0]);
    end
    n_tests++;
    if (c_rk[0] !== 32'h12345678 || c_va[0] !== 64'hDEAD_BEEF_0000_0040) begin
      n_fail++; $display("FAIL only_reth got rk=%h va=%h exp 12345678/deadbeef00000040", c_rk[0], c_va[0]);
    end
    exp_done++;
  endtask

  task automatic test_psn_wrap();
    int got;
    pulse_meta(1'b1, 32'd2500, 32'h0, 24'h1, 24'hFFFFFE, 32'h1, 64'h0);
    collect(3, got);
    n_tests++; if (got !== 3) begin n_fail++; $display("FAIL wrap_count got %0d exp 3", got); end
    n_tests++; if (c_op[0] !== 8'h06 || c_psn[0] !== 24'hFFFFFE || c_len[0] !== 16'd1024) begin n_fail++; $display("FAIL wrap_p0 got %h/%h/%0d exp 06/fffffe/1024", c_op[0], c_psn[0], c_len[0]); end
    n_tests++; if (c_op[1] !== 8'h07 || c_psn[1] !== 24'hFFFFFF || c_len[1] !== 16'd1024) begin n_fail++; $display("FAIL wrap_p1 got %h/%h/%0d exp 07/ffffff/1024", c_op[1], c_psn[1], c_len[1]); end
    n_tests++; if (c_op[2] !== 8'h08 || c_psn[2] !== 24'h000000 || c_len[2] !== 16'd452) begin n_fail++; $display("FAIL wrap_p2 got %h/%h/%0d exp 08/000000/452", c_op[2], c_psn[2], c_len[2]); end
    exp_done++;
  endtask

  task automatic test_zero_and_qp_update();
    int got;
    pulse_meta(1'b1, 32'd0, 32'h5, 24'h5, 24'h000777, 32'h5, 64'h5);
    collect(1, got);
    n_tests++;
    if (got !== 1 || c_op[0] !== 8'h0A || c_len[0] !== 16'd0 || c_rl[0] !== 32'd0) begin
      n_fail++; $display("FAIL zero_len got n=%0d op=%h len=%0d rl=%0d exp 1/0a/0/0", got, c_op[0], c_len[0], c_rl[0]);
    end
    exp_done++;
    n_tests++; if (xfer_done_cnt !== 16'(exp_done)) begin n_fail++; $display("FAIL zero_done got %0d exp %0d", xfer_done_cnt, exp_done); end
    pulse_meta(1'b0, 32'd2048, 32'h6, 24'h6, 24'h000900, 32'h6, 64'h6);
    repeat (4) @(negedge clk);
    n_tests++; if (m_desc_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL qp_update got valid=%b busy=%b exp 0/0", m_desc_valid, busy); end
  endtask

  task automatic test_stall();
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic r;
    logic [127:0] held;
    logic [7:0] eop;
    pulse_meta(1'b1, 32'd8000, 32'hAAAA5555, 24'h000321, 24'h000100, 32'hAC100001, 64'h77);
    while (got < 8 && cyc < 400) begin
      if (stalled) begin
        n_tests++;
        if (m_desc_valid !== 1'b1 || {m_opcode, m_psn, m_pkt_length, m_reth_length, m_dest_qp, m_ip_dest[23:0]} !== held) begin
          n_fail++; $display("FAIL stall_hold got valid=%b op=%h psn=%h exp held", m_desc_valid, m_opcode, m_psn);
        end
      end
      r = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
      m_desc_ready = r;
      stalled = m_desc_valid & ~r;
      held = {m_opcode, m_psn, m_pkt_length, m_reth_length, m_dest_qp, m_ip_dest[23:0]};
      if (m_desc_valid && r) begin
        c_op[got] = m_opcode; c_psn[got] = m_psn; c_len[got] = m_pkt_length;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    m_desc_ready = 1'b0;
    n_tests++; if (got !== 8) begin n_fail++; $display("FAIL stall_count got %0d exp 8", got); end
    for (int i = 0; i < 8; i++) begin
      eop = (i == 0) ? 8'h06 : ((i == 7) ? 8'h08 : 8'h07);
      n_tests++;
      if (c_op[i] !== eop || c_psn[i] !== 24'h100 + 24'(i) || c_len[i] !== ((i == 7) ? 16'd832 : 16'd1024)) begin
        n_fail++; $display("FAIL stall_pkt%0d got op=%h psn=%h len=%0d exp op=%h psn=%h", i, c_op[i], c_psn[i], c_len[i], eop, 24'h100 + 24'(i));
      end
    end
    exp_done++;
    n_tests++; if (xfer_done_cnt !== 16'(exp_done)) begin n_fail++; $display("FAIL stall_done got %0d exp %0d", xfer_done_cnt, exp_done); end
  endtask

  task automatic test_drop_and_reset();
    int got;
    int cyc;
    pulse_meta(1'b1, 32'd4096, 32'hBEEF0000, 24'h000111, 24'h000200, 32'h1, 64'h0000_0000_0000_8000);
    collect(1, got);
    pulse_meta(1'b1, 32'd64, 32'h0BAD0BAD, 24'h000999, 24'h000900, 32'h2, 64'h9);
    n_tests++; if (meta_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt got %0d exp 1", meta_drop_cnt); end
    collect(1, got);
    n_tests++;
    if (got !== 1 || c_op[0] !== 8'h07 || c_psn[0] !== 24'h000201 || c_rk[0] !== 32'hBEEF0000 || c_qp[0] !== 24'h000111) begin
      n_fail++; $display("FAIL drop_unchanged got op=%h psn=%h rk=%h qp=%h exp 07/000201/beef0000/000111", c_op[0], c_psn[0], c_rk[0], c_qp[0]);
    end
    cyc = 0;
    while (m_desc_valid !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++; if (m_desc_valid !== 1'b1 || m_psn !== 24'h000202) begin n_fail++; $display("FAIL pkt3_present got valid=%b psn=%h exp 1/000202", m_desc_valid, m_psn); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (m_desc_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid got valid=%b busy=%b exp 0/0", m_desc_valid, busy); end
    repeat (3) @(negedge clk);
    n_tests++; if (m_desc_valid !== 1'b0 || meta_drop_cnt !== 16'd0 || xfer_done_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_after got valid=%b drop=%0d done=%0d exp 0/0/0", m_desc_valid, meta_drop_cnt, xfer_done_cnt); end
  endtask

  initial begin
    rst = 1'b1; s_meta_valid = 1'b0; s_start_transfer = 1'b0; s_dma_length = 32'd0;
    s_r_key = 32'd0; s_rem_qpn = 24'd0; s_loc_psn = 24'd0; s_rem_ip_addr = 32'd0;
    s_rem_addr = 64'd0; m_desc_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_four_packets();
    test_single_packet();
    test_psn_wrap();
    test_zero_and_qp_update();
    test_stall();
    test_drop_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
